// File: rtl/osd_cpu_bridge_if.sv
// osd_cpu_bridge_if
// Groups the CPU-side request/config signals and the VRAM-side write port of
// the OSD CPU bridge into one bundle.
//   master : CPU / test side. Drives requests, blanking, vertical drive and
//            config. Observes the VRAM port and status.
//   slave  : the bridge itself.
// Signal summary:
//   CMD_STB_i, CMD_WAs_i, CMD_WDs_i : write request strobe (edge), address, data
//   BLANK_i, XVD_i, CPU_USE_i       : video timing and blanking bypass
//   CFG_i, CFG_ARM_i, CLR_i         : config word, arm strobe, sticky clear
//   VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o : VRAM write port
//   CFG_o, LEVELs_o, OVF_o, CFG_PEND_o : shadowed config and status
interface osd_cpu_bridge_if #(
    parameter int C_AW         = 10,
    parameter int C_DW         = 8,
    parameter int C_CFG_W      = 48,
    parameter int C_FIFO_DEPTH = 8
) ();
    logic                            CMD_STB_i;
    logic [C_AW-1:0]                 CMD_WAs_i;
    logic [C_DW-1:0]                 CMD_WDs_i;
    logic                            BLANK_i;
    logic                            XVD_i;
    logic                            CPU_USE_i;
    logic [C_CFG_W-1:0]              CFG_i;
    logic                            CFG_ARM_i;
    logic                            CLR_i;
    logic                            VRAM_WE_o;
    logic [C_AW-1:0]                 VRAM_WAs_o;
    logic [C_DW-1:0]                 VRAM_WDs_o;
    logic [C_CFG_W-1:0]              CFG_o;
    logic [$clog2(C_FIFO_DEPTH):0]   LEVELs_o;
    logic                            OVF_o;
    logic                            CFG_PEND_o;

    modport master (
        output CMD_STB_i, CMD_WAs_i, CMD_WDs_i, BLANK_i, XVD_i, CPU_USE_i,
               CFG_i, CFG_ARM_i, CLR_i,
        input  VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o, CFG_o, LEVELs_o, OVF_o,
               CFG_PEND_o
    );

    modport slave (
        input  CMD_STB_i, CMD_WAs_i, CMD_WDs_i, BLANK_i, XVD_i, CPU_USE_i,
               CFG_i, CFG_ARM_i, CLR_i,
        output VRAM_WE_o, VRAM_WAs_o, VRAM_WDs_o, CFG_o, LEVELs_o, OVF_o,
               CFG_PEND_o
    );
endinterface

// File: rtl/osd_cpu_bridge.sv
// osd_cpu_bridge
// Queues CPU VRAM writes and drains them only during video blanking, with at
// most C_MAX_BURST writes per blanking interval (unless CPU_USE_i bypasses the
// gating). Also shadows a display-config word so that it changes only at
// vertical sync.
// Ports:
//   CK_i    : system clock
//   SYS_R_i : synchronous active-high reset
//   bus     : osd_cpu_bridge_if.slave (requests, timing, config, VRAM port,
//             status)
module osd_cpu_bridge #(
    parameter int C_AW         = 10,
    parameter int C_DW         = 8,
    parameter int C_FIFO_DEPTH = 8,
    parameter int C_CFG_W      = 48,
    parameter int C_MAX_BURST  = 4
) (
    input  logic              CK_i,
    input  logic              SYS_R_i,
    osd_cpu_bridge_if.slave   bus
);
    localparam int PW = $clog2(C_FIFO_DEPTH);
    localparam int EW = C_AW + C_DW;
    localparam int CW = $clog2(C_MAX_BURST + 1);
    localparam logic [PW:0]   DEPTHC = (PW+1)'(C_FIFO_DEPTH);
    localparam logic [PW:0]   PONE   = (PW+1)'(1);
    localparam logic [CW-1:0] MAXC   = CW'(C_MAX_BURST);
    localparam logic [CW-1:0] CONE   = CW'(1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_BLK, S_WRITE, S_HOLD} state_t;

    state_t            state;
    logic              stb_q, blank_q, xvd_q, arm_q;
    logic              push_valid;
    logic [EW-1:0]     push_entry;
    logic [EW-1:0]     mem [C_FIFO_DEPTH];
    logic [PW:0]       wr_ptr, rd_ptr, level, level_next;
    logic              full, empty, push, pop;
    logic [CW-1:0]     burst_cnt;
    logic              burst_done;
    logic [C_AW-1:0]   last_addr;
    logic [C_DW-1:0]   last_data;
    logic [EW-1:0]     head;
    logic [C_CFG_W-1:0] staging, cfg_shadow;
    logic              cfg_pend, ovf;
    logic              blank_rise, blank_fall, xvd_fall, arm_rise, write_ok, we;

    assign level      = wr_ptr - rd_ptr;
    assign full       = (level == DEPTHC);
    assign empty      = (level == '0);
    assign head       = mem[rd_ptr[PW-1:0]];
    assign blank_rise = bus.BLANK_i & ~blank_q;
    assign blank_fall = ~bus.BLANK_i & blank_q;
    assign xvd_fall   = ~bus.XVD_i & xvd_q;
    assign arm_rise   = bus.CFG_ARM_i & ~arm_q;

    // Write enable is decoded from the registered state so that the popped
    // entry appears on the VRAM port in the same cycle, and so that a reset
    // arriving mid-burst can suppress it immediately.
    assign write_ok   = ~empty & (bus.CPU_USE_i | (burst_cnt < MAXC));
    assign we         = (state == S_WRITE) & write_ok & ~SYS_R_i;
    assign pop        = we;
    // A simultaneous pop frees a slot, so a push into a full queue is still
    // accepted in that cycle.
    assign push       = push_valid & (~full | pop);
    assign level_next = level + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
    assign burst_done = (burst_cnt >= MAXC) | (pop & (burst_cnt == MAXC - CONE));

    // Edge detectors and request capture. The strobe history resets to 1 so
    // a strobe already high when reset releases does not count as a request.
    always_ff @(posedge CK_i) begin
        if (SYS_R_i) begin
            stb_q      <= 1'b1;
            blank_q    <= 1'b0;
            xvd_q      <= 1'b0;
            arm_q      <= 1'b0;
            push_valid <= 1'b0;
            push_entry <= '0;
        end else begin
            stb_q      <= bus.CMD_STB_i;
            blank_q    <= bus.BLANK_i;
            xvd_q      <= bus.XVD_i;
            arm_q      <= bus.CFG_ARM_i;
            push_valid <= bus.CMD_STB_i & ~stb_q;
            if (bus.CMD_STB_i & ~stb_q)
                push_entry <= {bus.CMD_WAs_i, bus.CMD_WDs_i};
        end
    end

    // Queue storage; contents need no reset because the pointers define
    // validity.
    always_ff @(posedge CK_i) begin
        if (!SYS_R_i && push)
            mem[wr_ptr[PW-1:0]] <= push_entry;
    end

    // Queue pointers carry one extra MSB to tell full from empty.
    always_ff @(posedge CK_i) begin
        if (SYS_R_i) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + PONE;
            if (pop)  rd_ptr <= rd_ptr + PONE;
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear wins.
    always_ff @(posedge CK_i) begin
        if (SYS_R_i)
            ovf <= 1'b0;
        else if (push_valid && !push)
            ovf <= 1'b1;
        else if (bus.CLR_i)
            ovf <= 1'b0;
    end

    // Drain FSM with burst counter and the held VRAM address/data. A blanking
    // fall ends a burst after the current write; an empty queue returns to
    // idle; the burst limit parks the FSM until blanking ends.
    always_ff @(posedge CK_i) begin
        if (SYS_R_i) begin
            state     <= S_IDLE;
            burst_cnt <= '0;
            last_addr <= '0;
            last_data <= '0;
        end else begin
            if (blank_rise)
                burst_cnt <= pop ? CONE : '0;
            else if (pop && burst_cnt != MAXC)
                burst_cnt <= burst_cnt + CONE;
            if (pop) begin
                last_addr <= head[EW-1:C_DW];
                last_data <= head[C_DW-1:0];
            end
            case (state)
                S_IDLE:
                    if (!empty) state <= S_WAIT_BLK;
                S_WAIT_BLK:
                    if ((bus.BLANK_i || bus.CPU_USE_i) && !empty) state <= S_WRITE;
                S_WRITE:
                    if (!bus.CPU_USE_i && blank_fall)
                        state <= S_WAIT_BLK;
                    else if (level_next == '0)
                        state <= S_IDLE;
                    else if (!bus.CPU_USE_i && burst_done)
                        state <= S_HOLD;
                S_HOLD:
                    if (blank_fall) state <= S_WAIT_BLK;
                default:
                    state <= S_IDLE;
            endcase
        end
    end

    // Config shadowing. When an arm and a vertical-sync edge coincide, the
    // older staged value is applied and the newly armed one stays pending.
    always_ff @(posedge CK_i) begin
        if (SYS_R_i) begin
            staging    <= '0;
            cfg_shadow <= '0;
            cfg_pend   <= 1'b0;
        end else begin
            if (xvd_fall && cfg_pend)
                cfg_shadow <= staging;
            if (arm_rise) begin
                staging  <= bus.CFG_i;
                cfg_pend <= 1'b1;
            end else if (xvd_fall && cfg_pend) begin
                cfg_pend <= 1'b0;
            end
        end
    end

    assign bus.VRAM_WE_o  = we;
    assign bus.VRAM_WAs_o = we ? head[EW-1:C_DW] : last_addr;
    assign bus.VRAM_WDs_o = we ? head[C_DW-1:0]  : last_data;
    assign bus.CFG_o      = cfg_shadow;
    assign bus.LEVELs_o   = level;
    assign bus.OVF_o      = ovf;
    assign bus.CFG_PEND_o = cfg_pend;
endmodule

// File: tb/tb_osd_cpu_bridge.sv
// tb_osd_cpu_bridge
// Self-checking bench for osd_cpu_bridge. A queue of expected entries models
// the write FIFO; every VRAM write must match its head, and expected levels,
// write counts and overflow are derived arithmetically from what was issued.
module tb_osd_cpu_bridge;
    localparam int AW    = 10;
    localparam int DW    = 8;
    localparam int DEPTH = 8;
    localparam int CFGW  = 48;
    localparam int MAXB  = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    osd_cpu_bridge_if #(.C_AW(AW), .C_DW(DW), .C_CFG_W(CFGW), .C_FIFO_DEPTH(DEPTH)) bus ();

    osd_cpu_bridge #(
        .C_AW(AW), .C_DW(DW), .C_FIFO_DEPTH(DEPTH), .C_CFG_W(CFGW), .C_MAX_BURST(MAXB)
    ) dut (
        .CK_i(clk),
        .SYS_R_i(rst),
        .bus(bus)
    );

    int checks = 0;
    int failures = 0;
    int wr_count = 0;
    int cycle = 0;
    int wr_cycles[$];
    logic [AW+DW-1:0] model_q[$];
    logic [AW+DW-1:0] mon_entry;
    logic [AW-1:0] last_a = '0;
    logic [DW-1:0] last_d = '0;
    logic model_ovf = 1'b0;

    task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            failures++;
            $display("[TB] FAIL %s actual=0x%0h expected=0x%0h", tag, actual, expected);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // One strobe pulse; address is scrambled after the edge cycle so only the
    // value present in the edge cycle can reach the queue.
    task automatic applyStimulus(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic clr);
        if (model_q.size() < DEPTH) model_q.push_back({a, d});
        else model_ovf = 1'b1;
        bus.CMD_STB_i = 1'b1;
        bus.CMD_WAs_i = a;
        bus.CMD_WDs_i = d;
        tick(1);
        bus.CMD_STB_i = 1'b0;
        bus.CMD_WAs_i = AW'($urandom);
        bus.CMD_WDs_i = DW'($urandom);
        bus.CLR_i = clr;
        tick(1);
        bus.CLR_i = 1'b0;
    endtask

    task automatic blankWindow(input int len);
        bus.BLANK_i = 1'b1;
        tick(len);
        bus.BLANK_i = 1'b0;
        tick(3);
    endtask

    task automatic armCfg(input logic [CFGW-1:0] v);
        bus.CFG_i = v;
        bus.CFG_ARM_i = 1'b1;
        tick(1);
        bus.CFG_ARM_i = 1'b0;
        tick(1);
    endtask

    always @(posedge clk) cycle++;

    // Write monitor: every write must be the oldest expected entry; between
    // writes the VRAM port must hold the last written values.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.VRAM_WE_o === 1'b1) begin
                wr_count++;
                wr_cycles.push_back(cycle);
                if (model_q.size() == 0) begin
                    checkOutput("unexpected_write", 1, 0);
                end else begin
                    mon_entry = model_q.pop_front();
                    checkOutput("write_addr", 64'(bus.VRAM_WAs_o), 64'(mon_entry[AW+DW-1:DW]));
                    checkOutput("write_data", 64'(bus.VRAM_WDs_o), 64'(mon_entry[DW-1:0]));
                    last_a = mon_entry[AW+DW-1:DW];
                    last_d = mon_entry[DW-1:0];
                end
            end else begin
                checkOutput("addr_hold", 64'(bus.VRAM_WAs_o), 64'(last_a));
                checkOutput("data_hold", 64'(bus.VRAM_WDs_o), 64'(last_d));
            end
        end
    end

    initial begin
        int start, n, lvl, exp_lvl, exp_w, len;
        logic exp_ovf, found;

        bus.CMD_STB_i = 1'b1;
        bus.CMD_WAs_i = '0;
        bus.CMD_WDs_i = '0;
        bus.BLANK_i   = 1'b0;
        bus.XVD_i     = 1'b1;
        bus.CPU_USE_i = 1'b0;
        bus.CFG_i     = '0;
        bus.CFG_ARM_i = 1'b0;
        bus.CLR_i     = 1'b0;
        rst = 1'b1;
        tick(3);
        checkOutput("rst_we", 64'(bus.VRAM_WE_o), 0);
        checkOutput("rst_level", 64'(bus.LEVELs_o), 0);
        checkOutput("rst_cfg", 64'(bus.CFG_o), 0);
        checkOutput("rst_pend", 64'(bus.CFG_PEND_o), 0);

        // Strobe held high through reset release must not queue anything.
        rst = 1'b0;
        tick(4);
        checkOutput("stb_held_reset_level", 64'(bus.LEVELs_o), 0);
        bus.CMD_STB_i = 1'b0;
        tick(1);

        // Three writes held off by blanking, then issued back to back.
        start = wr_count;
        applyStimulus(10'h005, 8'h41, 1'b0);
        applyStimulus(10'h006, 8'h42, 1'b0);
        applyStimulus(10'h007, 8'h43, 1'b0);
        tick(2);
        checkOutput("t1_level", 64'(bus.LEVELs_o), 3);
        checkOutput("t1_no_write", 64'(wr_count - start), 0);
        wr_cycles.delete();
        blankWindow(10);
        checkOutput("t1_writes", 64'(wr_count - start), 3);
        checkOutput("t1_consecutive", (wr_cycles.size() == 3) ? 64'(wr_cycles[2] - wr_cycles[0]) : 64'hFFFF, 2);
        checkOutput("t1_level_after", 64'(bus.LEVELs_o), 0);

        // Burst limit: six queued, four per blanking interval.
        for (int i = 0; i < 6; i++) applyStimulus(AW'($urandom), DW'($urandom), 1'b0);
        tick(2);
        checkOutput("t2_level", 64'(bus.LEVELs_o), 6);
        start = wr_count;
        blankWindow(20);
        checkOutput("t2_burst1", 64'(wr_count - start), MAXB);
        checkOutput("t2_level_mid", 64'(bus.LEVELs_o), 2);
        blankWindow(20);
        checkOutput("t2_burst2", 64'(wr_count - start), 6);
        checkOutput("t2_level_end", 64'(bus.LEVELs_o), 0);

        // Overflow: nine into depth eight; clear collides with a drop.
        for (int i = 0; i < 9; i++) applyStimulus(AW'($urandom), DW'($urandom), 1'b0);
        tick(2);
        checkOutput("t3_ovf", 64'(bus.OVF_o), 1);
        checkOutput("t3_level_full", 64'(bus.LEVELs_o), DEPTH);
        applyStimulus(AW'($urandom), DW'($urandom), 1'b1);
        tick(1);
        checkOutput("t3_ovf_beats_clr", 64'(bus.OVF_o), 1);
        bus.CLR_i = 1'b1;
        tick(1);
        bus.CLR_i = 1'b0;
        model_ovf = 1'b0;
        checkOutput("t3_ovf_cleared", 64'(bus.OVF_o), 0);
        start = wr_count;
        blankWindow(20);
        blankWindow(20);
        checkOutput("t3_drain_writes", 64'(wr_count - start), DEPTH);
        checkOutput("t3_level_end", 64'(bus.LEVELs_o), 0);
        checkOutput("t3_model_drained", 64'(model_q.size()), 0);

        // Config shadowing: last arm wins, applied the cycle after XVD falls.
        armCfg(48'h123);
        armCfg(48'h456);
        checkOutput("t4_pend", 64'(bus.CFG_PEND_o), 1);
        checkOutput("t4_cfg_unchanged", 64'(bus.CFG_o), 0);
        bus.XVD_i = 1'b0;
        @(negedge clk);
        checkOutput("t4_cfg_not_yet", 64'(bus.CFG_o), 0);
        tick(1);
        checkOutput("t4_cfg_applied", 64'(bus.CFG_o), 64'h456);
        checkOutput("t4_pend_clear", 64'(bus.CFG_PEND_o), 0);
        bus.XVD_i = 1'b1;
        tick(2);
        armCfg(48'hABC);
        bus.CFG_i = 48'hDEF;
        bus.CFG_ARM_i = 1'b1;
        bus.XVD_i = 1'b0;
        tick(1);
        bus.CFG_ARM_i = 1'b0;
        checkOutput("t4_coincide_cfg", 64'(bus.CFG_o), 64'hABC);
        checkOutput("t4_coincide_pend", 64'(bus.CFG_PEND_o), 1);
        bus.XVD_i = 1'b1;
        tick(2);
        bus.XVD_i = 1'b0;
        tick(1);
        checkOutput("t4_second_cfg", 64'(bus.CFG_o), 64'hDEF);
        checkOutput("t4_second_pend", 64'(bus.CFG_PEND_o), 0);
        bus.XVD_i = 1'b1;
        tick(1);

        // CPU_USE bypass: no blanking, no burst limit; held strobe = one request.
        bus.CPU_USE_i = 1'b1;
        start = wr_count;
        for (int i = 0; i < 5; i++) applyStimulus(AW'($urandom), DW'($urandom), 1'b0);
        tick(10);
        checkOutput("t5_writes", 64'(wr_count - start), 5);
        checkOutput("t5_level", 64'(bus.LEVELs_o), 0);
        start = wr_count;
        bus.CMD_WAs_i = AW'($urandom);
        bus.CMD_WDs_i = DW'($urandom);
        model_q.push_back({bus.CMD_WAs_i, bus.CMD_WDs_i});
        bus.CMD_STB_i = 1'b1;
        tick(10);
        bus.CMD_STB_i = 1'b0;
        tick(8);
        checkOutput("t5_held_stb_writes", 64'(wr_count - start), 1);
        bus.CPU_USE_i = 1'b0;
        tick(2);

        // Randomized fill / blanking rounds against arithmetic expectations.
        for (int it = 0; it < 6; it++) begin
            lvl = model_q.size();
            n = $urandom_range(1, 6);
            for (int i = 0; i < n; i++) begin
                applyStimulus(AW'($urandom), DW'($urandom), 1'b0);
                tick($urandom_range(0, 2));
            end
            exp_lvl = (lvl + n > DEPTH) ? DEPTH : lvl + n;
            exp_ovf = (lvl + n > DEPTH);
            tick(2);
            checkOutput("rnd_level", 64'(bus.LEVELs_o), 64'(exp_lvl));
            checkOutput("rnd_ovf", 64'(bus.OVF_o), 64'(exp_ovf));
            bus.CLR_i = 1'b1;
            tick(1);
            bus.CLR_i = 1'b0;
            model_ovf = 1'b0;
            start = wr_count;
            len = $urandom_range(6, 20);
            blankWindow(len);
            exp_w = (exp_lvl > MAXB) ? MAXB : exp_lvl;
            checkOutput("rnd_burst", 64'(wr_count - start), 64'(exp_w));
            checkOutput("rnd_level_after", 64'(bus.LEVELs_o), 64'(exp_lvl - exp_w));
        end
        repeat (3) blankWindow(10);
        checkOutput("rnd_drained", 64'(bus.LEVELs_o), 0);

        // Reset in the middle of a burst.
        for (int i = 0; i < 4; i++) applyStimulus(AW'($urandom), DW'($urandom), 1'b0);
        tick(2);
        armCfg(48'h5A5);
        bus.BLANK_i = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 10 && !found; i++) begin
            tick(1);
            if (bus.VRAM_WE_o === 1'b1) found = 1'b1;
        end
        if (!found) checkOutput("t6_write_timeout", 0, 1);
        rst = 1'b1;
        #1;
        checkOutput("t6_we_in_reset", 64'(bus.VRAM_WE_o), 0);
        model_q.delete();
        last_a = '0;
        last_d = '0;
        bus.BLANK_i = 1'b0;
        tick(2);
        checkOutput("t6_level", 64'(bus.LEVELs_o), 0);
        checkOutput("t6_addr", 64'(bus.VRAM_WAs_o), 0);
        checkOutput("t6_data", 64'(bus.VRAM_WDs_o), 0);
        checkOutput("t6_ovf", 64'(bus.OVF_o), 0);
        checkOutput("t6_pend", 64'(bus.CFG_PEND_o), 0);
        checkOutput("t6_cfg", 64'(bus.CFG_o), 0);
        rst = 1'b0;
        start = wr_count;
        tick(5);
        checkOutput("t6_no_writes_after", 64'(wr_count - start), 0);
        checkOutput("t6_level_after", 64'(bus.LEVELs_o), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        failures++;
        $display("[TB] FAIL watchdog actual=timeout expected=completion");
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
